cb_mem_bank_loader: RTL and testbench
=====================================

// Module: cb_mem_bank_loader
// PURPOSE
// - Initiator side of the connection/switch-block memory-bank config port (enable/address/data_in).
// - Consumes a serial bitstream over valid/ready and emits one single-cycle write per config bit.
// - Walks every SRAM bit of one tile: block-select field first, then bit-within-block.
// - Sits between the fabric-level bitstream source and the per-tile decoder plus mem blocks.
// PARAMETERS
// - ADDR_W       7                 total address width driven to the tile
// - BIT_AW       3                 low-field width: bit index inside a mem block
// - NUM_BLOCKS   11                number of mem blocks (decoder outputs) in the tile
// - BLOCK_SIZES  44'h22666666666   4 bits per block, block 0 in LSB nibble; 9x6 + 2x2 = 58 bits total
// PORTS
// - prog_clk  in   1         programming clock
// - pReset    in   1         asynchronous active-high reset
// - start     in   1         one-cycle pulse; begins a load when idle or done
// - bs_data   in   1         bitstream bit
// - bs_valid  in   1         bs_data is valid
// - bs_ready  out  1         loader accepts bs_data this cycle
// - enable    out  1         write strobe to the tile decoder
// - address   out  [0:6]     [0:BIT_AW-1] = bit index, [BIT_AW:ADDR_W-1] = block index; position 0 is MSB
// - data_in   out  1         config bit value to write
// - busy      out  1         load in progress
// - done      out  1         load complete; held until the next start
// - crc_err   out  1         CRC mismatch, valid while done=1
// BEHAVIOUR
// - One clock: prog_clk. Reset is asynchronous and active-high: pReset.
// - Reset values: all outputs 0, FSM in IDLE, counters 0.
// - FSM states: IDLE, LOAD, CHECK, DONE.
//   - IDLE/DONE + start -> LOAD. This clears done and crc_err and zeroes blk/bit.
//   - In LOAD, bs_ready = 1. A transfer is accepted when bs_valid & bs_ready.
//   - Accept in cycle N -> enable=1, address={bit,blk}, data_in=bs_data, all registered, in cycle N+1 only.
//   - If no transfer is accepted in a cycle, enable=0 in the following cycle. address and data_in hold their last value.
//   - After each accepted bit, bit increments. When bit == BLOCK_SIZES[blk]-1, bit wraps to 0 and blk increments.
//   - Last bit accepted (blk == NUM_BLOCKS-1, bit == its size-1) -> DONE, or -> CHECK when CRC is enabled.
//   - DONE: busy=0, done=1, bs_ready=0. done rises in the same cycle as the final enable pulse.
// - start while busy is ignored. A start coincident with pReset is ignored.
// - pReset during a load: outputs clear immediately. Tile SRAM already written is not rolled back.
//   The next start restarts at block 0, bit 0.
// - Every accepted bit produces exactly one enable pulse: no gaps, skips or duplicate addresses.
// - Block sizes of 0 are illegal. Behaviour for them is undefined and flagged by an assertion.
// CONFIGURATION
// - Macro CFG_LOADER_CRC_EN.
// - Defined:
//   - CRC-8 over all config bits, polynomial 0x07, init 0x00, MSB-first.
//     Per bit: crc = {crc[6:0],1'b0} ^ ((crc[7]^b) ? 8'h07 : 8'h00).
//   - In CHECK, bs_ready=1 and 8 further bits are accepted, MSB first. These bits produce no enable pulses.
//   - After the 8th bit -> DONE, with crc_err = (received != computed).
// - Undefined: the CHECK state, CRC register and CRC counter are absent. crc_err is tied to 0.
// STRUCTURE
// - Shared package cfg_loader_pkg:
//   - state enum typedef
//   - CRC8_POLY constant
//   - function blk_size(BLOCK_SIZES, idx)
// - One sub-module: cfg_crc8_serial (en, bit, clear -> crc[7:0]). Instantiated only under CFG_LOADER_CRC_EN.
// - Top level holds the FSM, the blk/bit counters and the output registers.
// TESTING
// - Reset: assert pReset mid-cycle -> enable, address, data_in, busy, done, bs_ready are 0 asynchronously.
// - Full load, continuous valid, 58 bits:
//   - 58 enable pulses in consecutive cycles
//   - pulse 1: blk 0, bit 0; pulse 6: blk 0, bit 5; pulse 55: blk 9, bit 0; pulse 58: blk 10, bit 1
//   - done=1 with pulse 58
// - Throttled: bs_valid low every 3rd cycle -> enable low the cycle after each gap.
//   Address sequence identical to the full load; data_in matches the stream.
// - start pulsed at bit 20 -> ignored.
//   start after done -> done=0, first pulse at blk 0, bit 0.
// - pReset after 20 accepted bits -> outputs 0; a new start writes from blk 0, bit 0 with no stale enable.
// - CFG_LOADER_CRC_EN, 58-bit stream 0x2A5... plus the correct CRC -> crc_err=0.
//   Same stream with bit 30 flipped -> crc_err=1 with done=1.
//   No enable pulses occur during the CRC bits.

Source files
------------

// File: rtl/cfg_loader_pkg.sv
// Shared definitions for the memory-bank configuration loader.
// Holds the loader state encoding, the CRC-8 polynomial, the block-size
// lookup helper and the serial CRC step used when CFG_LOADER_CRC_EN is set.
package cfg_loader_pkg;

    // Loader FSM states; CHECK is only reachable when the CRC option is built in
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } loader_state_t;

    // CRC-8 polynomial x^8 + x^2 + x + 1
    localparam logic [7:0] CRC8_POLY = 8'h07;

    // Each block size is a 4-bit nibble; block 0 sits in the least significant nibble
    localparam int SIZE_W     = 4;
    localparam int MAX_BLOCKS = 16;

    // Size (in bits) of mem block idx, taken from the packed size table
    function automatic logic [SIZE_W-1:0] blk_size(
        input logic [SIZE_W*MAX_BLOCKS-1:0] sizes,
        input int                           idx
    );
        return sizes[idx*SIZE_W +: SIZE_W];
    endfunction

    // One MSB-first serial CRC-8 step for a single incoming bit
    function automatic logic [7:0] crc8_step(
        input logic [7:0] crc,
        input logic       b
    );
        return {crc[6:0], 1'b0} ^ ((crc[7] ^ b) ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/cfg_crc8_serial.sv
// Bit-serial CRC-8 accumulator (poly 0x07, init 0x00, MSB-first).
// Only built when CFG_LOADER_CRC_EN is defined; the loader instantiates it
// under the same macro, so the default build carries no CRC logic at all.
`ifdef CFG_LOADER_CRC_EN
module cfg_crc8_serial
    import cfg_loader_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       bit_val,
    input  logic       clear,
    output logic [7:0] crc
);

    logic [7:0] crc_reg;

    // Accumulate one bit per enabled cycle; clear wins so a restart begins from init
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_reg <= 8'h00;
        end else if (clear) begin
            crc_reg <= 8'h00;
        end else if (en) begin
            crc_reg <= crc8_step(crc_reg, bit_val);
        end
    end

    assign crc = crc_reg;

endmodule
`endif

// File: rtl/cb_mem_bank_loader.sv
// Initiator for the connection/switch-block memory-bank config port.
// Takes a serial bitstream over valid/ready and turns every accepted bit
// into one registered single-cycle write (enable/address/data_in), walking
// bit-within-block inside each block, blocks in ascending order.
// Optional feature: define CFG_LOADER_CRC_EN to append an 8-bit CRC check
// phase after the last config bit; otherwise crc_err is tied low.
module cb_mem_bank_loader
    import cfg_loader_pkg::*;
#(
    parameter int                       ADDR_W      = 7,
    parameter int                       BIT_AW      = 3,
    parameter int                       NUM_BLOCKS  = 11,
    parameter logic [4*NUM_BLOCKS-1:0]  BLOCK_SIZES = 44'h22666666666
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              bs_data,
    input  logic              bs_valid,
    output logic              bs_ready,
    output logic              enable,
    output logic [0:ADDR_W-1] address,
    output logic              data_in,
    output logic              busy,
    output logic              done,
    output logic              crc_err
);

    localparam int BLK_AW = ADDR_W - BIT_AW;
    localparam logic [SIZE_W*MAX_BLOCKS-1:0] SIZES_EXT = (SIZE_W*MAX_BLOCKS)'(BLOCK_SIZES);

    loader_state_t       state_reg, state_next;
    logic [BLK_AW-1:0]   blk_reg, blk_next;
    logic [BIT_AW-1:0]   bit_reg, bit_next;
    logic                enable_reg, enable_next;
    logic [ADDR_W-1:0]   address_reg, address_next;
    logic                data_reg, data_next;

    logic                accept;
    logic                go;
    logic                last_bit;
    logic                last_blk;

    // Per-block last bit index and illegal-size flag, resolved at elaboration
    logic [BIT_AW-1:0]   last_bit_tbl [NUM_BLOCKS];
    logic [NUM_BLOCKS-1:0] zero_size;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BLOCKS; gi++) begin : g_blk
            localparam logic [SIZE_W-1:0] SZ = blk_size(SIZES_EXT, gi);
            assign last_bit_tbl[gi] = BIT_AW'(SZ - SIZE_W'(1));
            assign zero_size[gi]    = (SZ == '0);
        end
    endgenerate

`ifdef CFG_LOADER_CRC_EN
    logic [7:0] crc_val;
    logic [7:0] rx_reg, rx_next;
    logic [7:0] rx_word;
    logic [2:0] cnt_reg, cnt_next;
    logic       crc_err_reg, crc_err_next;
    logic       crc_en;

    // Only config bits feed the CRC; the trailing CRC bits are compared, not hashed
    assign crc_en = accept && (state_reg == ST_LOAD);

    cfg_crc8_serial u_crc (
        .clk     (prog_clk),
        .rst     (pReset),
        .en      (crc_en),
        .bit_val (bs_data),
        .clear   (go),
        .crc     (crc_val)
    );
`endif

    // Handshake and status decode straight from the state register
    assign bs_ready = (state_reg == ST_LOAD) || (state_reg == ST_CHECK);
    assign busy     = (state_reg == ST_LOAD) || (state_reg == ST_CHECK);
    assign done     = (state_reg == ST_DONE);
    assign accept   = bs_valid && bs_ready;
    assign go       = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));

    assign last_bit = (bit_reg == last_bit_tbl[blk_reg]);
    assign last_blk = (blk_reg == BLK_AW'(NUM_BLOCKS - 1));

    // Bit index lands in the MSB end, so address[0:BIT_AW-1] is the bit field
    assign enable  = enable_reg;
    assign address = address_reg;
    assign data_in = data_reg;

`ifdef CFG_LOADER_CRC_EN
    assign crc_err = crc_err_reg;
`else
    assign crc_err = 1'b0;
`endif

    // Next-state, counter and write-port logic
    always_comb begin
        state_next   = state_reg;
        blk_next     = blk_reg;
        bit_next     = bit_reg;
        enable_next  = 1'b0;
        address_next = address_reg;
        data_next    = data_reg;
`ifdef CFG_LOADER_CRC_EN
        rx_next      = rx_reg;
        cnt_next     = cnt_reg;
        crc_err_next = crc_err_reg;
        rx_word      = {rx_reg[6:0], bs_data};
`endif
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next = ST_LOAD;
                    blk_next   = '0;
                    bit_next   = '0;
`ifdef CFG_LOADER_CRC_EN
                    crc_err_next = 1'b0;
                    cnt_next     = '0;
                    rx_next      = '0;
`endif
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    enable_next  = 1'b1;
                    address_next = {bit_reg, blk_reg};
                    data_next    = bs_data;
                    if (last_bit) begin
                        bit_next = '0;
                        if (last_blk) begin
`ifdef CFG_LOADER_CRC_EN
                            state_next = ST_CHECK;
`else
                            state_next = ST_DONE;
`endif
                        end else begin
                            blk_next = blk_reg + BLK_AW'(1);
                        end
                    end else begin
                        bit_next = bit_reg + BIT_AW'(1);
                    end
                end
            end
            ST_CHECK: begin
`ifdef CFG_LOADER_CRC_EN
                // Received CRC arrives MSB first; no write strobes in this phase
                if (accept) begin
                    rx_next  = rx_word;
                    cnt_next = cnt_reg + 3'd1;
                    if (cnt_reg == 3'd7) begin
                        state_next   = ST_DONE;
                        crc_err_next = (rx_word != crc_val);
                    end
                end
`else
                state_next = ST_IDLE;
`endif
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Counters and registered write port; a zero-sized block is never legal
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            blk_reg     <= '0;
            bit_reg     <= '0;
            enable_reg  <= 1'b0;
            address_reg <= '0;
            data_reg    <= 1'b0;
        end else begin
            if (state_reg == ST_LOAD) begin
                assert (!zero_size[blk_reg]);
            end
            blk_reg     <= blk_next;
            bit_reg     <= bit_next;
            enable_reg  <= enable_next;
            address_reg <= address_next;
            data_reg    <= data_next;
        end
    end

`ifdef CFG_LOADER_CRC_EN
    // CRC check phase registers
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            rx_reg      <= '0;
            cnt_reg     <= '0;
            crc_err_reg <= 1'b0;
        end else begin
            rx_reg      <= rx_next;
            cnt_reg     <= cnt_next;
            crc_err_reg <= crc_err_next;
        end
    end
`endif

endmodule

// File: tb/tb_cb_mem_bank_loader.sv
// Self-checking bench for cb_mem_bank_loader.
// Reference: the expected write order is derived from the block-size table
// as a flat list of (block, bit) pairs; data is the random stream itself.
// With CFG_LOADER_CRC_EN defined, every load appends 8 CRC bits.
module tb_cb_mem_bank_loader;

`ifdef CFG_LOADER_CRC_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    logic       prog_clk;
    logic       pReset;
    logic       start;
    logic       bs_data;
    logic       bs_valid;
    logic       bs_ready;
    logic       enable;
    logic [0:6] address;
    logic       data_in;
    logic       busy;
    logic       done;
    logic       crc_err;

    int n_checks;
    int n_errors;

    int   total;
    int   exp_blk [64];
    int   exp_bit [64];
    logic sbits   [64];
    int   load_no;

    cb_mem_bank_loader dut (
        .prog_clk (prog_clk),
        .pReset   (pReset),
        .start    (start),
        .bs_data  (bs_data),
        .bs_valid (bs_valid),
        .bs_ready (bs_ready),
        .enable   (enable),
        .address  (address),
        .data_in  (data_in),
        .busy     (busy),
        .done     (done),
        .crc_err  (crc_err)
    );

    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_crc(input int n);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < n; i++)
            c = {c[6:0], 1'b0} ^ ((c[7] ^ sbits[i]) ? 8'h07 : 8'h00);
        return c;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < total; i++) sbits[i] = 1'($urandom_range(0, 1));
    endtask

    // mode 0: continuous valid, 1: valid low every 3rd cycle, 2: random gaps
    task automatic run_load(input int mode, input int start_at, input int abort_at,
                            input logic [7:0] crc_word);
        int         idx;
        int         pulses;
        int         n_send;
        bit         acc;
        bit         was_data;
        bit         start_sent;
        bit         exp_err;
        logic [6:0] addr_v;
        logic [6:0] addr_e;
        idx        = 0;
        pulses     = 0;
        start_sent = 0;
        n_send     = total + (CRC_ON ? 8 : 0);
        exp_err    = CRC_ON && (crc_word != ref_crc(total));
        load_no++;

        bs_valid = 1'b0;
        start    = 1'b1;
        @(posedge prog_clk); #1;
        start = 1'b0;
        chk("start_done_clr", done, 1'b0);
        chk("start_busy", busy, 1'b1);
        chk("start_no_stale_en", enable, 1'b0);

        for (int cyc = 0; cyc < 2000; cyc++) begin
            bit v;
            case (mode)
                0:       v = 1'b1;
                1:       v = ((cyc % 3) != 2);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            bs_valid = v;
            if (!v)              bs_data = 1'($urandom_range(0, 1));
            else if (idx < total) bs_data = sbits[idx];
            else                  bs_data = crc_word[7 - (idx - total)];
            if (start_at >= 0 && idx == start_at && !start_sent) begin
                start      = 1'b1;
                start_sent = 1'b1;
            end
            chk("ready", bs_ready, 1'b1);
            acc      = v;
            was_data = (idx < total);
            @(posedge prog_clk); #1;
            start = 1'b0;
            if (acc) idx++;
            chk("enable", enable, acc && was_data);
            if (enable && pulses < total) begin
                addr_v = address;
                addr_e = {3'(exp_bit[pulses]), 4'(exp_blk[pulses])};
                chk("address", addr_v, addr_e);
                chk("data_in", data_in, sbits[pulses]);
                pulses++;
                if (pulses == 1)  chk("pulse1_addr", addr_v, 7'h00);
                if (pulses == 6)  chk("pulse6_addr", addr_v, 7'h50);
                if (pulses == 55) chk("pulse55_addr", addr_v, 7'h09);
                if (pulses == 58) chk("pulse58_addr", addr_v, 7'h1A);
            end
            chk("done", done, idx == n_send);
            if (abort_at >= 0 && idx == abort_at) begin
                bs_valid = 1'b0;
                #2 pReset = 1'b1;
                #1;
                chk("arst_enable", enable, 1'b0);
                chk("arst_address", address, 7'h00);
                chk("arst_data_in", data_in, 1'b0);
                chk("arst_busy", busy, 1'b0);
                chk("arst_done", done, 1'b0);
                chk("arst_ready", bs_ready, 1'b0);
                @(posedge prog_clk);
                @(negedge prog_clk) pReset = 1'b0;
                @(posedge prog_clk); #1;
                chk("arst_idle_en", enable, 1'b0);
                $display("load %0d: aborted by reset after %0d bits, %0d pulses", load_no, idx, pulses);
                return;
            end
            if (idx == n_send) break;
        end
        if (idx != n_send) chk("timeout_bits", idx, n_send);
        bs_valid = 1'b0;
        chk("pulses", pulses, total);
        chk("end_busy", busy, 1'b0);
        chk("end_ready", bs_ready, 1'b0);
        chk("crc_err", crc_err, exp_err);
        bs_valid = 1'b1;
        @(posedge prog_clk); #1;
        bs_valid = 1'b0;
        chk("post_done_no_en", enable, 1'b0);
        chk("post_done_hold", done, 1'b1);
        $display("load %0d: mode %0d, %0d pulses, crc_err %0b", load_no, mode, pulses, crc_err);
    endtask

    initial begin
        logic [43:0] sizes_v;
        logic [57:0] pat;
        logic [7:0]  cw;
        n_checks = 0;
        n_errors = 0;
        load_no  = 0;
        pReset   = 1'b1;
        start    = 1'b0;
        bs_valid = 1'b0;
        bs_data  = 1'b0;

        // Flatten the size table into the expected write order
        sizes_v = 44'h22666666666;
        total   = 0;
        for (int b = 0; b < 11; b++) begin
            int sz;
            sz = int'(sizes_v[4*b +: 4]);
            for (int i = 0; i < sz; i++) begin
                exp_blk[total] = b;
                exp_bit[total] = i;
                total++;
            end
        end

        #1;
        chk("rst_enable", enable, 1'b0);
        chk("rst_address", address, 7'h00);
        chk("rst_data_in", data_in, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ready", bs_ready, 1'b0);
        chk("rst_crc_err", crc_err, 1'b0);

        // start held across a reset edge must not launch a load
        start = 1'b1;
        @(posedge prog_clk); #1;
        start = 1'b0;
        @(negedge prog_clk) pReset = 1'b0;
        @(posedge prog_clk); #1;
        chk("start_in_reset_busy", busy, 1'b0);

        fill_random();
        run_load(0, -1, -1, ref_crc(total));
        fill_random();
        run_load(1, 20, -1, ref_crc(total));
        fill_random();
        run_load(2, -1, 20, ref_crc(total));
        fill_random();
        run_load(0, -1, -1, ref_crc(total));
        fill_random();
        run_load(2, 33, -1, ref_crc(total));

`ifdef CFG_LOADER_CRC_EN
        pat = 58'h2A5C3F01B7E9D4;
        for (int i = 0; i < total; i++) sbits[i] = pat[57 - i];
        cw = ref_crc(total);
        run_load(0, -1, -1, cw);
        sbits[30] = ~sbits[30];
        run_load(1, -1, -1, cw);
`else
        pat = '0;
        cw  = '0;
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
